// File: rtl/pattern_memory.sv
// Pattern word store: filled during a LOADING session, committed, then served to
// the sequencer with registered reads. Reads past the committed length return zero.
module pattern_memory #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int MEMORY_QTY   = 16
) (
  input  logic                    slow_clock,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    load_commit,
  input  logic                    w_en,
  input  logic [ADDRESS_SIZE-1:0] w_addr,
  input  logic [WORD_SIZE-1:0]    w_data,
  input  logic                    r_en,
  input  logic [ADDRESS_SIZE-1:0] r_addr,
  output logic [WORD_SIZE-1:0]    r_data,
  output logic                    r_ready,
  output logic [ADDRESS_SIZE:0]   length,
  output logic                    w_error
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_SIZE:0]   length_q, length_d;
  logic                    w_error_q, w_error_d;
  logic                    r_ready_q, r_ready_d;
  logic [WORD_SIZE-1:0]    r_data_q, r_data_d;
  logic [WORD_SIZE-1:0]    mem [MEMORY_QTY];

  logic                    w_addr_in_range;
  logic                    write_ok;
  logic [ADDRESS_SIZE:0]   w_addr_next;

  // When the array spans the whole address space every w_addr is legal.
  generate
    if (MEMORY_QTY >= (2 ** ADDRESS_SIZE)) begin : g_full
      assign w_addr_in_range = 1'b1;
    end else begin : g_partial
      localparam logic [ADDRESS_SIZE:0] QTY = (ADDRESS_SIZE + 1)'(MEMORY_QTY);
      assign w_addr_in_range = ({1'b0, w_addr} < QTY);
    end
  endgenerate

  assign write_ok    = (state_q == LOADING) && w_en && w_addr_in_range && !load_start;
  assign w_addr_next = {1'b0, w_addr} + {{ADDRESS_SIZE{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    w_error_d = w_error_q;
    r_data_d  = r_data_q;

    if ((state_q == READY) && r_en) begin
      r_data_d = ({1'b0, r_addr} < length_q) ? mem[r_addr] : '0;
    end

    if (write_ok && (w_addr_next > length_q)) begin
      length_d = w_addr_next;
    end
    if (w_en && !write_ok) begin
      w_error_d = 1'b1;
    end

    // load_start wins over commit and over any write in the same cycle.
    if (load_start) begin
      state_d   = LOADING;
      length_d  = '0;
      w_error_d = 1'b0;
    end else if ((state_q == LOADING) && load_commit) begin
      state_d = (length_d != '0) ? READY : EMPTY;
    end

    r_ready_d = (state_d == READY);
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      state_q   <= EMPTY;
      length_q  <= '0;
      w_error_q <= 1'b0;
      r_ready_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      length_q  <= length_d;
      w_error_q <= w_error_d;
      r_ready_q <= r_ready_d;
      r_data_q  <= r_data_d;
    end
  end

  // Contents survive reset; length alone says which words are valid.
  always_ff @(posedge slow_clock) begin
    if (write_ok) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data  = r_data_q;
  assign r_ready = r_ready_q;
  assign length  = length_q;
  assign w_error = w_error_q;

endmodule
